// File: rtl/stream_gen_sequencer.sv
// Burst sequencer for a one-shot bit-stream generator: accepts a repeat/gap command,
// pulses start once per frame, spaces frames by idle gaps, and reports completion or abort.
module stream_gen_sequencer #(
  parameter int STREAM_LEN  = 8,
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = 16,
  parameter int GAP_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_repeat,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  output logic             start_out,
  output logic             gen_reset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam int FRAME = STREAM_LEN * HOLD_CYCLES;
  localparam int FT_W  = $clog2(FRAME + 1);

  typedef enum logic [2:0] {IDLE, START, RUN, GAP, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic [FT_W-1:0]  frame_tmr;
  logic [GAP_W-1:0] gap_tmr;
  logic             accept;
  logic             abort_hit;
  logic             frame_last;
  logic [CNT_W-1:0] cnt_inc;

  assign accept     = (state == IDLE) && cmd_valid && cmd_ready;
  assign abort_hit  = abort && (state != IDLE);
  assign frame_last = (state == RUN) && (frame_tmr == '0);
  assign cnt_inc    = burst_cnt + CNT_W'(1);

  // Abort overrides every transition, including the final RUN cycle.
  always_comb begin
    state_nxt = state;
    if (abort_hit) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (accept) state_nxt = (cmd_repeat != '0) ? START : DONE;
        START: state_nxt = RUN;
        RUN: begin
          if (frame_last) begin
            if (cnt_inc == rep_q)    state_nxt = DONE;
            else if (gap_q == '0)    state_nxt = START;
            else                     state_nxt = GAP;
          end
        end
        GAP:   if (gap_tmr == '0) state_nxt = START;
        DONE:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      start_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      burst_cnt <= '0;
      gen_reset <= 1'b1;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      start_out <= (state_nxt == START);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      gen_reset <= abort_hit;
      if (accept)
        burst_cnt <= '0;
      else if (frame_last && !abort_hit)
        burst_cnt <= cnt_inc;
    end
  end

  // Command fields and timers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      rep_q <= cmd_repeat;
      gap_q <= cmd_gap;
    end
    if (state == START)
      frame_tmr <= FT_W'(FRAME - 1);
    else if (state == RUN && frame_tmr != '0)
      frame_tmr <= frame_tmr - FT_W'(1);
    if (frame_last)
      gap_tmr <= gap_q - GAP_W'(1);
    else if (state == GAP && gap_tmr != '0)
      gap_tmr <= gap_tmr - GAP_W'(1);
  end

endmodule

// File: doc/stream_gen_sequencer.md
Name: stream_gen_sequencer

Overview:
Controller for a one-shot bit-stream generator configured with LOOP=0. It accepts a burst command (repeat count, inter-burst gap) over a valid/ready handshake. It then issues one start pulse per burst, times each frame, inserts idle gaps between frames, and reports completion. Optionally, it aborts the sequence and resets the generator.

Parameters:
STREAM_LEN, 8, bits per frame in the controlled generator (must match generator)
HOLD_CYCLES, 10, clocks per bit in the controlled generator (must match generator)
CNT_W, 16, width of repeat count and burst counter
GAP_W, 16, width of inter-burst gap field

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (registered)
cmd_repeat  in  CNT_W  number of frames to emit; sampled on handshake
cmd_gap  in  GAP_W  idle clocks between frames; sampled on handshake
abort  in  1  terminate current sequence
start_out  out  1  one-cycle start pulse to generator start_in
gen_reset  out  1  reset to generator
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when all frames are complete
burst_cnt  out  CNT_W  frames completed in the current sequence

Behaviour:
- Frame length: localparam FRAME = STREAM_LEN*HOLD_CYCLES.
  - Frame timer width is clog2(FRAME+1).
  - Gap timer is GAP_W bits.
- Reset values:
  - state=IDLE, cmd_ready=0, start_out=0, busy=0, done=0, burst_cnt=0, gen_reset=1.
  - On the first cycle after reset deasserts: gen_reset=0 and cmd_ready=1.
- All outputs are registered.
- cmd_ready=1 exactly when state==IDLE, excluding the reset cycle.
- busy=1 in every state except IDLE.
- Handshake: a command is accepted in cycle T when cmd_valid&&cmd_ready.
  - cmd_repeat and cmd_gap are latched at T.
  - burst_cnt clears to 0 at T+1.
  - cmd_valid while not ready is ignored; no queuing.
- States:
  - IDLE: on accept, go to START if repeat>0; otherwise go to DONE.
  - START: start_out=1 for exactly this one cycle; load frame timer; go to RUN.
  - RUN: lasts exactly FRAME cycles.
    - On the last cycle, burst_cnt increments. The new value is visible the following cycle.
    - If burst_cnt+1==repeat, go to DONE.
    - Else if gap==0, go to START.
    - Else go to GAP.
  - GAP: lasts exactly gap cycles, then goes to START.
  - DONE: done=1 for one cycle; busy remains 1; go to IDLE.
- Timing with accept at T:
  - First start_out at T+1.
  - Frame period is 1+FRAME+gap cycles.
  - Last start_out is followed by FRAME RUN cycles, then DONE.
  - cmd_ready returns the cycle after DONE.
- Repeat=0: DONE at T+1, IDLE at T+2, no start_out.
- Abort:
  - Has priority over all transitions.
  - Sampled in cycle k while state!=IDLE. At k+1: state=IDLE, gen_reset=1 for one cycle, busy=0, cmd_ready=1, start_out=0, done=0.
  - burst_cnt holds its completed count at the time of abort.
  - If abort coincides with the last RUN cycle, abort wins: no DONE, and burst_cnt is not incremented.
  - Abort in IDLE is ignored.
  - A command accepted at k+1 (gen_reset high) is legal; its start_out appears at k+2.
- Reset mid-sequence: returns immediately to reset values, including gen_reset=1.
- burst_cnt never wraps: repeat ≤ 2^CNT_W−1, and the count stops at repeat.

Test Plan:
- Defaults (FRAME=80), accept repeat=3, gap=5 at T:
  - start_out at T+1, T+87, T+173.
  - burst_cnt steps 1,2,3 at T+82, T+168, T+254.
  - done at T+254; cmd_ready high at T+255.
- Repeat=3, gap=0 at T:
  - start_out at T+1, T+82, T+163.
  - done at T+244.
  - No idle cycle between frames.
- Repeat=0 at T:
  - done at T+1, cmd_ready at T+2.
  - start_out never asserts; burst_cnt=0.
- Repeat=5, gap=2, abort at T+40:
  - At T+41: gen_reset=1 for one cycle, busy=0, cmd_ready=1.
  - burst_cnt=0; no done.
  - New command at T+41 gives start_out at T+42.
- Abort on the final RUN cycle of repeat=1 (T+81):
  - No done, burst_cnt=0, gen_reset pulse at T+82.
  - Also: cmd_valid held high throughout a sequence accepts no second command until cmd_ready returns.
- Reset asserted mid-GAP for 3 cycles:
  - All outputs at reset values and gen_reset=1 during reset.
  - gen_reset=0 and cmd_ready=1 on the first cycle after release.
